cdp1802_dma_responder: RTL and testbench

//  CPU-side counterpart of the 1861 Pixie: services the video chip's DMA-out

---
 rtl/cdp1802_dma_responder.sv | 117 +++++++++++
 tb/tb_cdp1802_dma_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdp1802_dma_responder.sv
// CPU-side DMA-out and interrupt-acknowledge sequencer for an 1802 core paired with a Pixie video chip.
// Steals machine cycles for display fetches, auto-increments R0, and runs INT cycles.
module cdp1802_dma_responder #(
    parameter logic [15:0] R0_RESET  = 16'h0000,
    parameter int          MAX_BURST = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic [1:0]  cpu_sc,
    input  logic        cpu_cyc_end,
    input  logic        dma_out_n,
    input  logic        int_req,
    input  logic        ie,
    input  logic        r0_load,
    input  logic [15:0] r0_value,
    input  logic [7:0]  mem_data_in,
    output logic [1:0]  SC,
    output logic        cpu_hold,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        int_ack,
    output logic        ie_clear,
    output logic [15:0] r0
);

    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        S_CPU = 2'd0,
        S_DMA = 2'd1,
        S_INT = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] burst_cnt;
    logic          dma_req;
    logic          int_ok;

    assign dma_req = !dma_out_n;
    assign int_ok  = int_req && ie;

    // data_valid, int_ack and ie_clear are single-clock pulses in the clock after
    // the machine-cycle tick that completed the DMA or INT cycle; no ready/backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_CPU;
            r0         <= R0_RESET;
            burst_cnt  <= '0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            int_ack    <= 1'b0;
            ie_clear   <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            int_ack    <= 1'b0;
            ie_clear   <= 1'b0;
            if (clk_enable) begin
                if (r0_load)
                    r0 <= r0_value;
                case (state)
                    S_CPU: begin
                        if (cpu_cyc_end) begin
                            if (dma_req)
                                state <= S_DMA;
                            else if (int_ok)
                                state <= S_INT;
                        end
                    end
                    S_DMA: begin
                        data_out   <= mem_data_in;
                        data_valid <= 1'b1;
                        // A core load in the same tick replaces the increment.
                        if (!r0_load)
                            r0 <= r0 + 16'd1;
                        if (dma_req && burst_cnt < LAST_BEAT) begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end else begin
                            burst_cnt <= '0;
                            state     <= int_ok ? S_INT : S_CPU;
                        end
                    end
                    S_INT: begin
                        int_ack  <= 1'b1;
                        ie_clear <= 1'b1;
                        state    <= S_CPU;
                    end
                    default: state <= S_CPU;
                endcase
            end
        end
    end

    always_comb begin
        SC       = cpu_sc;
        cpu_hold = 1'b0;
        mem_addr = 16'h0000;
        mem_rd   = 1'b0;
        case (state)
            S_DMA: begin
                SC       = 2'b10;
                cpu_hold = 1'b1;
                mem_addr = r0;
                mem_rd   = 1'b1;
            end
            S_INT: begin
                SC       = 2'b11;
                cpu_hold = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cdp1802_dma_responder.sv
// Scoreboard bench for cdp1802_dma_responder: directed scenarios then randomized machine cycles,
// checked against a per-machine-cycle behavioural model with queued expected display bytes.
module tb_cdp1802_dma_responder;

    localparam logic [15:0] R0_RST = 16'h0000;
    localparam int          MAXB   = 8;

    logic        clk;
    logic        reset;
    logic        clk_enable;
    logic [1:0]  cpu_sc;
    logic        cpu_cyc_end;
    logic        dma_out_n;
    logic        int_req;
    logic        ie;
    logic        r0_load;
    logic [15:0] r0_value;
    logic [7:0]  mem_data_in;
    logic [1:0]  SC;
    logic        cpu_hold;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        int_ack;
    logic        ie_clear;
    logic [15:0] r0;

    cdp1802_dma_responder #(.R0_RESET(R0_RST), .MAX_BURST(MAXB)) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .cpu_sc(cpu_sc),
        .cpu_cyc_end(cpu_cyc_end), .dma_out_n(dma_out_n), .int_req(int_req), .ie(ie),
        .r0_load(r0_load), .r0_value(r0_value), .mem_data_in(mem_data_in),
        .SC(SC), .cpu_hold(cpu_hold), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .data_out(data_out), .data_valid(data_valid), .int_ack(int_ack),
        .ie_clear(ie_clear), .r0(r0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Display memory contents as a fixed scramble of the address.
    function automatic logic [7:0] mem_fn(input logic [15:0] a);
        return a[7:0] ^ {a[12:8], a[15:13]} ^ 8'h3C;
    endfunction

    assign mem_data_in = mem_fn(mem_addr);

    int          vectors;
    int          miscompares;
    logic [7:0]  exp_q[$];
    logic        int_q[$];

    // Reference model: kind of the current machine cycle (0 CPU, 1 DMA, 2 INT).
    int          m_mode;
    int          m_beats;
    logic [15:0] m_r0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, check bus outputs against the model, then advance the model
    // by what the coming edge does.
    task automatic cyc(input logic tk, input logic ce, input logic dn, input logic ir,
                       input logic ien, input logic ld, input logic [15:0] val, input logic rst);
        logic [1:0] exp_sc;
        @(negedge clk);
        clk_enable  = tk;
        cpu_cyc_end = ce;
        dma_out_n   = dn;
        int_req     = ir;
        ie          = ien;
        r0_load     = ld;
        r0_value    = val;
        reset       = rst;
        cpu_sc      = 2'($urandom_range(0, 3));
        #1;
        exp_sc = (m_mode == 1) ? 2'b10 : (m_mode == 2) ? 2'b11 : cpu_sc;
        check("sc", 32'(SC), 32'(exp_sc));
        check("cpu_hold", 32'(cpu_hold), 32'(m_mode != 0));
        check("mem_rd", 32'(mem_rd), 32'(m_mode == 1));
        check("mem_addr", 32'(mem_addr), (m_mode == 1) ? 32'(m_r0) : 32'd0);
        check("r0", 32'(r0), 32'(m_r0));
        if (rst) begin
            m_mode  = 0;
            m_r0    = R0_RST;
            m_beats = 0;
        end else if (tk) begin
            case (m_mode)
                0: begin
                    if (ld) m_r0 = val;
                    if (ce) begin
                        if (!dn) m_mode = 1;
                        else if (ir && ien) m_mode = 2;
                    end
                end
                1: begin
                    exp_q.push_back(mem_fn(m_r0));
                    m_r0 = ld ? val : m_r0 + 16'd1;
                    m_beats++;
                    if (dn || m_beats >= MAXB) begin
                        m_beats = 0;
                        m_mode  = (ir && ien) ? 2 : 0;
                    end
                end
                default: begin
                    int_q.push_back(1'b1);
                    if (ld) m_r0 = val;
                    m_mode = 0;
                end
            endcase
        end
    endtask

    // A machine-cycle tick followed by one non-tick clock with the same (ignored) inputs.
    task automatic t(input logic ce, input logic dn, input logic ir, input logic ien,
                     input logic ld, input logic [15:0] val);
        cyc(1'b1, ce, dn, ir, ien, ld, val, 1'b0);
        cyc(1'b0, ce, dn, ir, ien, ld, val, 1'b0);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Monitor: pops expectations whenever the DUT presents a pulse.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (data_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL data_valid_unexpected: got data_out %0h expected no pulse at %0t",
                             data_out, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("data_out", 32'(data_out), 32'(e));
                end
            end
            if (int_ack === 1'b1 || ie_clear === 1'b1) begin
                if (int_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL int_ack_unexpected: got int_ack %0b ie_clear %0b expected no pulse at %0t",
                             int_ack, ie_clear, $time);
                end else begin
                    void'(int_q.pop_front());
                    check("int_ack_ie_clear", 32'({int_ack, ie_clear}), 32'(2'b11));
                end
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        clk_enable  = 1'b0;
        cpu_sc      = 2'b00;
        cpu_cyc_end = 1'b0;
        dma_out_n   = 1'b1;
        int_req     = 1'b0;
        ie          = 1'b0;
        r0_load     = 1'b0;
        r0_value    = 16'h0000;
        m_mode      = 0;
        m_beats     = 0;
        m_r0        = R0_RST;
        repeat (3) @(posedge clk);

        // Reset state and idle CPU cycles with no request.
        for (int i = 0; i < 4; i++) t(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
        check("strobes_idle", 32'({data_valid, int_ack, ie_clear}), 32'd0);

        // Full burst from 0900, one CPU cycle, then a final beat.
        t(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0900);
        t(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < MAXB; i++) t(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        settle();
        check("r0_after_burst", 32'(r0), 32'h0908);
        check("sc_cpu_after_burst", 32'(cpu_hold), 32'd0);
        t(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        t(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);

        // DMA and INT both pending: burst first, then the INT cycle.
        t(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < MAXB; i++) t(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        check("sc_int_cycle", 32'(SC), 32'(2'b11));
        t(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0);

        // INT masked by ie=0, then taken once ie rises.
        for (int i = 0; i < 3; i++) t(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        t(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        t(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        t(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);

        // R0 wrap and load-beats-increment.
        t(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFF);
        t(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        check("mem_addr_ffff", 32'(mem_addr), 32'hFFFF);
        t(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        settle();
        check("r0_wrap", 32'(r0), 32'h0000);
        t(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        t(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234);
        settle();
        check("r0_load_wins", 32'(r0), 32'h1234);

        // Reset during a DMA tick aborts the cycle without a data pulse.
        t(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        settle();
        check("r0_after_reset", 32'(r0), 32'(R0_RST));
        check("hold_after_reset", 32'(cpu_hold), 32'd0);

        // Randomized machine cycles.
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 2) != 0 ? 1 : 0), 1'($urandom_range(0, 2) == 0 ? 1 : 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0 ? 1 : 0),
                16'($urandom), 1'($urandom_range(0, 59) == 0 ? 1 : 0));
        end

        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        settle();
        check("data_q_drained", 32'(exp_q.size()), 32'd0);
        check("int_q_drained", 32'(int_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
